mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL use parameters: none; opcodes SHALL be the codebase aluop encodings LB=8'b11100000, LBU=8'b11100100, LH=8'b11100001, LHU=8'b11100101, LW=8'b11100011, SB=8'b11101000, SH=8'b11101001, SW=8'b11101011.
REQ-002 The block SHALL have ports as follows, one per line: name, direction, width, meaning.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  MEM-stage access request; held until done_o.
- aluop_i  in  8  access opcode per REQ-001.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned.
- stallreq_o  out  1  pipeline stall request.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load result, valid with done_o.
- misalign_o  out  1  alignment fault flag, valid with done_o.
- mem_ce_o  out  1  data RAM chip enable.
- mem_we_o  out  1  data RAM write enable.
- mem_addr_o  out  32  data RAM byte address.
- mem_sel_o  out  4  byte-lane enables; bit 3 = bits [31:24].
- mem_data_o  out  32  data RAM write data.
- mem_data_i  in  32  data RAM read data, combinational from the mem_* outputs.

Function
REQ-003 The block SHALL implement states IDLE, ACCESS, RESP; all outputs except stallreq_o SHALL be registered.
REQ-004 In IDLE with req_i=1 and a valid aligned opcode, the block SHALL register the bus outputs and go to ACCESS on the next edge.
REQ-005 In ACCESS, mem_ce_o SHALL be 1 for exactly one cycle, and the next state SHALL be RESP.
REQ-006 In RESP, done_o SHALL be 1 for exactly one cycle, the bus SHALL be idle (mem_ce_o=0, mem_we_o=0, mem_sel_o=0), and the next state SHALL be IDLE.
REQ-007 Latency SHALL be 2 cycles: request seen at edge N, bus active cycle N+1, done_o in cycle N+2.
REQ-008 A new request SHALL be accepted only in IDLE; req_i during RESP SHALL be ignored.
REQ-009 stallreq_o SHALL be combinational and equal (state==IDLE and req_i) or state==ACCESS, so that it is 0 in RESP.
REQ-010 Lane mapping SHALL be big-endian. Byte offsets 0..3 SHALL map to sel 1000, 0100, 0010, 0001. Halfword offsets 0 and 2 SHALL map to sel 1100 and 0011. Word accesses SHALL use sel 1111.
REQ-011 Store data SHALL be replicated across lanes: SB -> {4{wdata_i[7:0]}}, SH -> {2{wdata_i[15:0]}}, SW -> wdata_i; mem_we_o=1 only for stores.
REQ-012 Loads SHALL drive mem_we_o=0 and mem_data_o=0, and SHALL capture the selected lanes of mem_data_i at the end of ACCESS.
REQ-013 The captured load lanes SHALL be extended into rdata_o: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Stores SHALL return rdata_o=0.
REQ-014 mem_addr_o SHALL equal addr_i unmodified.
REQ-015 An LH/LHU/SH request with addr_i[0]=1, or an LW/SW request with addr_i[1:0]!=0, SHALL NOT access the bus. It SHALL go IDLE->RESP directly, with misalign_o=1 and rdata_o=0 in RESP.
REQ-016 A request with an opcode outside REQ-001 SHALL go IDLE->RESP with no bus access, misalign_o=0 and rdata_o=0.
REQ-017 misalign_o SHALL be 0 whenever done_o=0.

Reset
REQ-018 When rst=1 at a rising edge, the state SHALL become IDLE and every registered output SHALL be 0 after that edge, including mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o, done_o, rdata_o and misalign_o.
REQ-019 Reset asserted in ACCESS or RESP SHALL abort the access: no done_o pulse SHALL follow, and a write whose ACCESS edge coincides with the reset edge SHALL be treated as not performed.
REQ-020 While rst=1, stallreq_o SHALL be 0.

Verification
REQ-021 The bench SHALL cover these scenarios:
- SW addr=0x10, wdata=0x11223344 -> ACCESS cycle shows ce=1, we=1, sel=1111, data=0x11223344; done_o two cycles after the request.
- SB addr=0x13, wdata=0x000000AB -> sel=0001, mem_data_o=0xABABABAB; a following LW at 0x10 returns 0x112233AB.
- With RAM word 0x80FF7F01 at 0x20: LB at 0x20 -> 0xFFFFFF80; LBU at 0x21 -> 0x000000FF; LH at 0x22 -> 0x00007F01; LHU at 0x20 -> 0x000080FF.
- LW at 0x22 -> no ce pulse; done_o and misalign_o=1 one cycle after the request; rdata_o=0.
- rst pulsed during the ACCESS cycle of an LW -> no done_o; all outputs 0; the next request completes normally.
- stallreq_o trace for an LW: 1 in the request cycle, 1 in ACCESS, 0 in RESP; req_i held through RESP causes no second access.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response and data-RAM bus bundle for mem_access_ctrl.
// slave = the controller, master = the pipeline/RAM side.
interface mem_access_ctrl_if;
   logic        req_i;
   logic [7:0]  aluop_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        stallreq_o;
   logic        done_o;
   logic [31:0] rdata_o;
   logic        misalign_o;
   logic        mem_ce_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;

   modport slave (
      input  req_i, aluop_i, addr_i, wdata_i, mem_data_i,
      output stallreq_o, done_o, rdata_o, misalign_o,
             mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o
   );

   modport master (
      output req_i, aluop_i, addr_i, wdata_i, mem_data_i,
      input  stallreq_o, done_o, rdata_o, misalign_o,
             mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: big-endian lane select, store replication,
// load extension, alignment check, fixed two-cycle handshake to a data RAM.
//
// state  | meaning
// IDLE   | waiting for req_i; decodes opcode and alignment
// ACCESS | single bus cycle with mem_ce_o=1; load lanes captured at its end
// RESP   | done_o pulse with rdata_o/misalign_o; bus idle, req_i ignored
module mem_access_ctrl (
   input  logic                     clk,
   input  logic                     rst,
   mem_access_ctrl_if.slave         bus
);

   localparam logic [7:0] OP_LB  = 8'b11100000;
   localparam logic [7:0] OP_LBU = 8'b11100100;
   localparam logic [7:0] OP_LH  = 8'b11100001;
   localparam logic [7:0] OP_LHU = 8'b11100101;
   localparam logic [7:0] OP_LW  = 8'b11100011;
   localparam logic [7:0] OP_SB  = 8'b11101000;
   localparam logic [7:0] OP_SH  = 8'b11101001;
   localparam logic [7:0] OP_SW  = 8'b11101011;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t      state_q;
   logic [7:0]  op_q;
   logic [1:0]  off_q;
   logic        ce_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [3:0]  sel_q;
   logic [31:0] data_q;
   logic        done_q;
   logic [31:0] rdata_q;
   logic        misalign_q;

   logic        known_d;
   logic        misalign_d;
   logic        store_d;
   logic [3:0]  sel_d;
   logic [31:0] data_d;

   always_comb begin
      known_d    = 1'b1;
      misalign_d = 1'b0;
      store_d    = 1'b0;
      sel_d      = 4'b0000;
      data_d     = 32'h0;
      case (bus.aluop_i)
         OP_LB, OP_LBU: sel_d = 4'b1000 >> bus.addr_i[1:0];
         OP_SB: begin
            sel_d   = 4'b1000 >> bus.addr_i[1:0];
            store_d = 1'b1;
            data_d  = {4{bus.wdata_i[7:0]}};
         end
         OP_LH, OP_LHU: begin
            misalign_d = bus.addr_i[0];
            sel_d      = bus.addr_i[1] ? 4'b0011 : 4'b1100;
         end
         OP_SH: begin
            misalign_d = bus.addr_i[0];
            sel_d      = bus.addr_i[1] ? 4'b0011 : 4'b1100;
            store_d    = 1'b1;
            data_d     = {2{bus.wdata_i[15:0]}};
         end
         OP_LW: begin
            misalign_d = (bus.addr_i[1:0] != 2'b00);
            sel_d      = 4'b1111;
         end
         OP_SW: begin
            misalign_d = (bus.addr_i[1:0] != 2'b00);
            sel_d      = 4'b1111;
            store_d    = 1'b1;
            data_d     = bus.wdata_i;
         end
         default: known_d = 1'b0;
      endcase
   end

   // Lane extraction uses the opcode and offset latched at request time.
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_d;

   always_comb begin
      case (off_q)
         2'd0:    byte_v = bus.mem_data_i[31:24];
         2'd1:    byte_v = bus.mem_data_i[23:16];
         2'd2:    byte_v = bus.mem_data_i[15:8];
         default: byte_v = bus.mem_data_i[7:0];
      endcase
      half_v = off_q[1] ? bus.mem_data_i[15:0] : bus.mem_data_i[31:16];
      case (op_q)
         OP_LB:   load_d = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  load_d = {24'h0, byte_v};
         OP_LH:   load_d = {{16{half_v[15]}}, half_v};
         OP_LHU:  load_d = {16'h0, half_v};
         OP_LW:   load_d = bus.mem_data_i;
         default: load_d = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= 8'h0;
         off_q      <= 2'b00;
         ce_q       <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         sel_q      <= 4'b0000;
         data_q     <= 32'h0;
         done_q     <= 1'b0;
         rdata_q    <= 32'h0;
         misalign_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q     <= 1'b0;
               rdata_q    <= 32'h0;
               misalign_q <= 1'b0;
               if (bus.req_i) begin
                  if (!known_d || misalign_d) begin
                     state_q    <= S_RESP;
                     done_q     <= 1'b1;
                     misalign_q <= known_d & misalign_d;
                  end else begin
                     state_q <= S_ACCESS;
                     op_q    <= bus.aluop_i;
                     off_q   <= bus.addr_i[1:0];
                     ce_q    <= 1'b1;
                     we_q    <= store_d;
                     addr_q  <= bus.addr_i;
                     sel_q   <= sel_d;
                     data_q  <= data_d;
                  end
               end
            end
            S_ACCESS: begin
               state_q <= S_RESP;
               ce_q    <= 1'b0;
               we_q    <= 1'b0;
               sel_q   <= 4'b0000;
               data_q  <= 32'h0;
               done_q  <= 1'b1;
               rdata_q <= load_d;
            end
            S_RESP: begin
               state_q    <= S_IDLE;
               done_q     <= 1'b0;
               rdata_q    <= 32'h0;
               misalign_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.stallreq_o = !rst &&
                           (((state_q == S_IDLE) && bus.req_i) || (state_q == S_ACCESS));
   assign bus.done_o     = done_q;
   assign bus.rdata_o    = rdata_q;
   assign bus.misalign_o = misalign_q;
   assign bus.mem_ce_o   = ce_q;
   assign bus.mem_we_o   = we_q;
   assign bus.mem_addr_o = addr_q;
   assign bus.mem_sel_o  = sel_q;
   assign bus.mem_data_o = data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: bus-cycle checks inline, load results
// checked by a done_o monitor against a queue of expected responses.
module tb_mem_access_ctrl;

   localparam logic [7:0] OP_LB  = 8'b11100000;
   localparam logic [7:0] OP_LBU = 8'b11100100;
   localparam logic [7:0] OP_LH  = 8'b11100001;
   localparam logic [7:0] OP_LHU = 8'b11100101;
   localparam logic [7:0] OP_LW  = 8'b11100011;
   localparam logic [7:0] OP_SB  = 8'b11101000;
   localparam logic [7:0] OP_SH  = 8'b11101001;
   localparam logic [7:0] OP_SW  = 8'b11101011;

   typedef struct packed {
      logic [31:0] rdata;
      logic        mis;
   } resp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   resp_t exp_q[$];
   logic [31:0] ram [0:63];

   mem_access_ctrl_if bus_if();

   mem_access_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus_if.mem_data_i = ram[bus_if.mem_addr_o[7:2]];

   // RAM write is suppressed on a reset edge so an aborted store never lands.
   always @(posedge clk) begin
      if (!rst && bus_if.mem_ce_o && bus_if.mem_we_o) begin
         if (bus_if.mem_sel_o[3]) ram[bus_if.mem_addr_o[7:2]][31:24] <= bus_if.mem_data_o[31:24];
         if (bus_if.mem_sel_o[2]) ram[bus_if.mem_addr_o[7:2]][23:16] <= bus_if.mem_data_o[23:16];
         if (bus_if.mem_sel_o[1]) ram[bus_if.mem_addr_o[7:2]][15:8]  <= bus_if.mem_data_o[15:8];
         if (bus_if.mem_sel_o[0]) ram[bus_if.mem_addr_o[7:2]][7:0]   <= bus_if.mem_data_o[7:0];
      end
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (bus_if.done_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0");
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            chk("resp_rdata", bus_if.rdata_o, e.rdata);
            chk("resp_misalign", {31'h0, bus_if.misalign_o}, {31'h0, e.mis});
         end
      end else if (bus_if.misalign_o !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL misalign_without_done actual=%b expected=0", bus_if.misalign_o);
      end
   end

   task automatic do_req(input string nm, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic em,
                         input logic use_bus, input logic [3:0] es, input logic ew,
                         input logic [31:0] ed, input logic hold);
      @(negedge clk);
      bus_if.req_i   = 1'b1;
      bus_if.aluop_i = op;
      bus_if.addr_i  = a;
      bus_if.wdata_i = wd;
      #1;
      chk({nm, "_stall_req"}, {31'h0, bus_if.stallreq_o}, 32'h1);
      exp_q.push_back('{rdata: er, mis: em});
      @(negedge clk);
      if (use_bus) begin
         chk({nm, "_ce"}, {31'h0, bus_if.mem_ce_o}, 32'h1);
         chk({nm, "_we"}, {31'h0, bus_if.mem_we_o}, {31'h0, ew});
         chk({nm, "_sel"}, {28'h0, bus_if.mem_sel_o}, {28'h0, es});
         chk({nm, "_wdata"}, bus_if.mem_data_o, ed);
         chk({nm, "_addr"}, bus_if.mem_addr_o, a);
         chk({nm, "_stall_acc"}, {31'h0, bus_if.stallreq_o}, 32'h1);
         chk({nm, "_done_early"}, {31'h0, bus_if.done_o}, 32'h0);
         @(negedge clk);
      end
      chk({nm, "_resp_ce"}, {31'h0, bus_if.mem_ce_o}, 32'h0);
      chk({nm, "_resp_we"}, {31'h0, bus_if.mem_we_o}, 32'h0);
      chk({nm, "_resp_sel"}, {28'h0, bus_if.mem_sel_o}, 32'h0);
      chk({nm, "_resp_done"}, {31'h0, bus_if.done_o}, 32'h1);
      chk({nm, "_resp_stall"}, {31'h0, bus_if.stallreq_o}, 32'h0);
      if (hold) begin
         @(negedge clk);
         chk({nm, "_hold_ce"}, {31'h0, bus_if.mem_ce_o}, 32'h0);
         chk({nm, "_hold_done"}, {31'h0, bus_if.done_o}, 32'h0);
      end
      bus_if.req_i = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus_if.req_i   = 1'b0;
      bus_if.aluop_i = 8'h0;
      bus_if.addr_i  = 32'h0;
      bus_if.wdata_i = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_stall", {31'h0, bus_if.stallreq_o}, 32'h0);
      rst = 1'b0;
      #1;
      chk("rst_ce", {31'h0, bus_if.mem_ce_o}, 32'h0);
      chk("rst_we", {31'h0, bus_if.mem_we_o}, 32'h0);
      chk("rst_sel", {28'h0, bus_if.mem_sel_o}, 32'h0);
      chk("rst_addr", bus_if.mem_addr_o, 32'h0);
      chk("rst_data", bus_if.mem_data_o, 32'h0);
      chk("rst_done", {31'h0, bus_if.done_o}, 32'h0);
      chk("rst_rdata", bus_if.rdata_o, 32'h0);
      chk("rst_misalign", {31'h0, bus_if.misalign_o}, 32'h0);

      do_req("sw10",  OP_SW,  32'h10, 32'h11223344, 32'h0, 1'b0, 1'b1, 4'b1111, 1'b1, 32'h11223344, 1'b0);
      do_req("sb13",  OP_SB,  32'h13, 32'h000000AB, 32'h0, 1'b0, 1'b1, 4'b0001, 1'b1, 32'hABABABAB, 1'b0);
      do_req("lw10",  OP_LW,  32'h10, 32'hFFFFFFFF, 32'h112233AB, 1'b0, 1'b1, 4'b1111, 1'b0, 32'h0, 1'b0);
      do_req("sw20",  OP_SW,  32'h20, 32'h80FF7F01, 32'h0, 1'b0, 1'b1, 4'b1111, 1'b1, 32'h80FF7F01, 1'b0);
      do_req("lb20",  OP_LB,  32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1, 4'b1000, 1'b0, 32'h0, 1'b0);
      do_req("lbu21", OP_LBU, 32'h21, 32'h0, 32'h000000FF, 1'b0, 1'b1, 4'b0100, 1'b0, 32'h0, 1'b0);
      do_req("lh22",  OP_LH,  32'h22, 32'h0, 32'h00007F01, 1'b0, 1'b1, 4'b0011, 1'b0, 32'h0, 1'b0);
      do_req("lhu20", OP_LHU, 32'h20, 32'h0, 32'h000080FF, 1'b0, 1'b1, 4'b1100, 1'b0, 32'h0, 1'b0);
      do_req("sh12",  OP_SH,  32'h12, 32'h0000BEEF, 32'h0, 1'b0, 1'b1, 4'b0011, 1'b1, 32'hBEEFBEEF, 1'b0);
      do_req("lw10b", OP_LW,  32'h10, 32'h0, 32'h1122BEEF, 1'b0, 1'b1, 4'b1111, 1'b0, 32'h0, 1'b0);
      do_req("lw22m", OP_LW,  32'h22, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0);
      do_req("sh21m", OP_SH,  32'h21, 32'h1234, 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0);
      do_req("badop", 8'h00,  32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0);
      do_req("lwhold", OP_LW, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 1'b1, 4'b1111, 1'b0, 32'h0, 1'b1);

      // Reset in the ACCESS cycle of a load: no response may follow.
      @(negedge clk);
      bus_if.req_i   = 1'b1;
      bus_if.aluop_i = OP_LW;
      bus_if.addr_i  = 32'h20;
      @(negedge clk);
      chk("abort_ce", {31'h0, bus_if.mem_ce_o}, 32'h1);
      rst = 1'b1;
      bus_if.req_i = 1'b0;
      @(negedge clk);
      bus_if.req_i = 1'b1;
      #1;
      chk("abort_stall_in_rst", {31'h0, bus_if.stallreq_o}, 32'h0);
      chk("abort_ce0", {31'h0, bus_if.mem_ce_o}, 32'h0);
      chk("abort_sel0", {28'h0, bus_if.mem_sel_o}, 32'h0);
      chk("abort_addr0", bus_if.mem_addr_o, 32'h0);
      chk("abort_done0", {31'h0, bus_if.done_o}, 32'h0);
      chk("abort_rdata0", bus_if.rdata_o, 32'h0);
      bus_if.req_i = 1'b0;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", {31'h0, bus_if.done_o}, 32'h0);
      end

      do_req("lw_after", OP_LW, 32'h10, 32'h0, 32'h1122BEEF, 1'b0, 1'b1, 4'b1111, 1'b0, 32'h0, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
